// File: rtl/riscv_cpu_pkg.sv
// Shared definitions for the multi-cycle RISC-V control path.
// Contents: control FSM state enum, base-ISA opcode constants, and the
// encodings used on the imm_sel, wb_sel and pc_mux control buses.
package riscv_cpu_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        WAIT_I = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WAIT_D = 3'd5,
        WB     = 3'd6,
        TRAP   = 3'd7
    } state_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_LOAD = 2'd1;
    localparam logic [1:0] WB_PC4  = 2'd2;

    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_JUMP   = 2'd1;
    localparam logic [1:0] PC_BRANCH = 2'd2;

    localparam logic [3:0] ALU_ADD = 4'd0;

endpackage

// File: rtl/control_decoder.sv
// Combinational instruction decoder for control_fsm.
// Ports:
//   i_opcode, i_funct3, i_funct7_b5 : instruction fields taken from IR
//   o_alu_op                        : ALU operation (zero-extended above bit 3)
//   o_data_a_mux / o_data_b_mux     : operand selects (A: 1 = PC, B: 1 = imm)
//   o_imm_sel, o_wb_sel             : immediate format / write-back source
//   o_legal                         : opcode is one of the supported classes
//   o_is_branch/load/store/jump     : instruction class flags for the FSM
module control_decoder
    import riscv_cpu_pkg::*;
#(
    parameter int ALU_OP_WIDTH = 4
) (
    input  logic [6:0]              i_opcode,
    input  logic [2:0]              i_funct3,
    input  logic                    i_funct7_b5,
    output logic [ALU_OP_WIDTH-1:0] o_alu_op,
    output logic                    o_data_a_mux,
    output logic                    o_data_b_mux,
    output logic [2:0]              o_imm_sel,
    output logic [1:0]              o_wb_sel,
    output logic                    o_legal,
    output logic                    o_is_branch,
    output logic                    o_is_load,
    output logic                    o_is_store,
    output logic                    o_is_jump
);

    always_comb begin
        o_alu_op     = '0;
        o_data_a_mux = 1'b0;
        o_data_b_mux = 1'b0;
        o_imm_sel    = IMM_I;
        o_wb_sel     = WB_ALU;
        o_legal      = 1'b1;
        o_is_branch  = 1'b0;
        o_is_load    = 1'b0;
        o_is_store   = 1'b0;
        o_is_jump    = 1'b0;
        o_alu_op[3:0] = ALU_ADD;

        case (i_opcode)
            OPC_LUI: begin
                o_data_b_mux = 1'b1;
                o_imm_sel    = IMM_U;
            end
            OPC_AUIPC: begin
                o_data_a_mux = 1'b1;
                o_data_b_mux = 1'b1;
                o_imm_sel    = IMM_U;
            end
            OPC_JAL: begin
                o_data_a_mux = 1'b1;
                o_data_b_mux = 1'b1;
                o_imm_sel    = IMM_J;
                o_wb_sel     = WB_PC4;
                o_is_jump    = 1'b1;
            end
            OPC_JALR: begin
                o_data_b_mux = 1'b1;
                o_imm_sel    = IMM_I;
                o_wb_sel     = WB_PC4;
                o_is_jump    = 1'b1;
            end
            OPC_BRANCH: begin
                // ALU forms PC + imm for the target; the comparator is separate.
                o_data_a_mux = 1'b1;
                o_imm_sel    = IMM_B;
                o_is_branch  = 1'b1;
            end
            OPC_LOAD: begin
                o_data_b_mux = 1'b1;
                o_imm_sel    = IMM_I;
                o_wb_sel     = WB_LOAD;
                o_is_load    = 1'b1;
            end
            OPC_STORE: begin
                o_data_b_mux = 1'b1;
                o_imm_sel    = IMM_S;
                o_is_store   = 1'b1;
            end
            OPC_OP_IMM: begin
                o_data_b_mux = 1'b1;
                o_imm_sel    = IMM_I;
                // Bit 30 is part of the immediate except for SRLI/SRAI.
                o_alu_op[3:0] = {(i_funct3 == 3'b101) & i_funct7_b5, i_funct3};
            end
            OPC_OP: begin
                o_alu_op[3:0] = {i_funct7_b5, i_funct3};
            end
            default: begin
                o_legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle control FSM: fetch / decode / execute / memory / write-back.
// Ports:
//   clk_i, rst_i                 : clock, asynchronous active-high reset
//   imem_req_o/gnt_i/rvalid_i    : instruction fetch handshake, imem_rdata_i word
//   dmem_req_o/we_o/gnt_i/rvalid_i : data memory handshake
//   branch_taken_i               : datapath comparator result
//   alu_op_o, data_*_mux_o, imm_sel_o, wb_sel_o : decode outputs from IR
//   reg_raddr_*_o, reg_waddr_o   : rs1/rs2/rd fields of IR
//   reg_we_o, pc_we_o, pc_mux_o  : write-back and PC update strobes
//   illegal_instr_o              : sticky illegal-opcode flag (cleared by reset)
//   state_o                      : current FSM state, for observation
// Handshake: a request is held high every cycle until its grant is sampled
// high on a rising edge; the transfer completes in that cycle. rvalid is a
// single-cycle pulse that arrives in a later cycle than the grant.
module control_fsm
    import riscv_cpu_pkg::*;
#(
    parameter int ADDR_WIDTH   = 5,
    parameter int ALU_OP_WIDTH = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    output logic                    imem_req_o,
    input  logic                    imem_gnt_i,
    input  logic                    imem_rvalid_i,
    input  logic [31:0]             imem_rdata_i,
    output logic                    dmem_req_o,
    output logic                    dmem_we_o,
    input  logic                    dmem_gnt_i,
    input  logic                    dmem_rvalid_i,
    input  logic                    branch_taken_i,
    output logic [ALU_OP_WIDTH-1:0] alu_op_o,
    output logic                    data_a_mux_o,
    output logic                    data_b_mux_o,
    output logic [2:0]              imm_sel_o,
    output logic [ADDR_WIDTH-1:0]   reg_raddr_a_o,
    output logic [ADDR_WIDTH-1:0]   reg_raddr_b_o,
    output logic [ADDR_WIDTH-1:0]   reg_waddr_o,
    output logic                    reg_we_o,
    output logic [1:0]              wb_sel_o,
    output logic [1:0]              pc_mux_o,
    output logic                    pc_we_o,
    output logic                    illegal_instr_o,
    output state_t                  state_o
);

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_ir;
    logic        r_illegal;

    logic        w_imem_req, w_dmem_req, w_dmem_we, w_reg_we, w_pc_we;
    logic [1:0]  w_pc_mux;
    logic        w_ir_load, w_set_illegal;
    logic        w_legal, w_is_branch, w_is_load, w_is_store, w_is_jump;
    logic        w_rd_nonzero;
    logic        w_unused_ir;

    control_decoder #(
        .ALU_OP_WIDTH(ALU_OP_WIDTH)
    ) u_decoder (
        .i_opcode     (r_ir[6:0]),
        .i_funct3     (r_ir[14:12]),
        .i_funct7_b5  (r_ir[30]),
        .o_alu_op     (alu_op_o),
        .o_data_a_mux (data_a_mux_o),
        .o_data_b_mux (data_b_mux_o),
        .o_imm_sel    (imm_sel_o),
        .o_wb_sel     (wb_sel_o),
        .o_legal      (w_legal),
        .o_is_branch  (w_is_branch),
        .o_is_load    (w_is_load),
        .o_is_store   (w_is_store),
        .o_is_jump    (w_is_jump)
    );

    // Remaining funct7/immediate bits are consumed by the datapath, not here.
    assign w_unused_ir  = ^{r_ir[31], r_ir[29:25]};
    assign w_rd_nonzero = |r_ir[11:7];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= FETCH;
            r_ir      <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_ir_load) begin
                r_ir <= imem_rdata_i;
            end
            if (w_set_illegal) begin
                r_illegal <= 1'b1;
            end
        end
    end

    always_comb begin
        w_next        = r_state;
        w_imem_req    = 1'b0;
        w_dmem_req    = 1'b0;
        w_dmem_we     = 1'b0;
        w_reg_we      = 1'b0;
        w_pc_we       = 1'b0;
        w_pc_mux      = PC_PLUS4;
        w_ir_load     = 1'b0;
        w_set_illegal = 1'b0;

        case (r_state)
            FETCH: begin
                w_imem_req = 1'b1;
                if (imem_gnt_i) begin
                    w_next = WAIT_I;
                end
            end
            WAIT_I: begin
                if (imem_rvalid_i) begin
                    w_ir_load = 1'b1;
                    w_next    = DECODE;
                end
            end
            DECODE: begin
                if (w_legal) begin
                    w_next = EXEC;
                end else begin
                    w_set_illegal = 1'b1;
                    w_next        = TRAP;
                end
            end
            EXEC: begin
                if (w_is_branch) begin
                    w_pc_we  = 1'b1;
                    w_pc_mux = branch_taken_i ? PC_BRANCH : PC_PLUS4;
                    w_next   = FETCH;
                end else if (w_is_load || w_is_store) begin
                    w_next = MEM;
                end else begin
                    w_next = WB;
                end
            end
            MEM: begin
                w_dmem_req = 1'b1;
                w_dmem_we  = w_is_store;
                if (dmem_gnt_i) begin
                    if (w_is_store) begin
                        // A store has nothing to write back; retire it here.
                        w_pc_we = 1'b1;
                        w_next  = FETCH;
                    end else begin
                        w_next = WAIT_D;
                    end
                end
            end
            WAIT_D: begin
                if (dmem_rvalid_i) begin
                    w_next = WB;
                end
            end
            WB: begin
                w_reg_we = w_rd_nonzero;
                w_pc_we  = 1'b1;
                w_pc_mux = w_is_jump ? PC_JUMP : PC_PLUS4;
                w_next   = FETCH;
            end
            TRAP: begin
                w_next = TRAP;
            end
            default: begin
                w_next = FETCH;
            end
        endcase
    end

    // Strobes are masked by rst_i so they drop the instant reset rises, not at
    // the next edge. Decode outputs follow IR, which the async reset clears.
    assign imem_req_o      = w_imem_req & ~rst_i;
    assign dmem_req_o      = w_dmem_req & ~rst_i;
    assign dmem_we_o       = w_dmem_we & ~rst_i;
    assign reg_we_o        = w_reg_we & ~rst_i;
    assign pc_we_o         = w_pc_we & ~rst_i;
    assign pc_mux_o        = rst_i ? PC_PLUS4 : w_pc_mux;
    assign illegal_instr_o = r_illegal;
    assign state_o         = r_state;

    assign reg_raddr_a_o = ADDR_WIDTH'(r_ir[19:15]);
    assign reg_raddr_b_o = ADDR_WIDTH'(r_ir[24:20]);
    assign reg_waddr_o   = ADDR_WIDTH'(r_ir[11:7]);

endmodule

// File: tb/tb_control_fsm.sv
module tb_control_fsm;
    import riscv_cpu_pkg::*;

    // Opcode values written out independently of the package.
    localparam logic [6:0] M_LUI    = 7'h37;
    localparam logic [6:0] M_AUIPC  = 7'h17;
    localparam logic [6:0] M_JAL    = 7'h6F;
    localparam logic [6:0] M_JALR   = 7'h67;
    localparam logic [6:0] M_BRANCH = 7'h63;
    localparam logic [6:0] M_LOAD   = 7'h03;
    localparam logic [6:0] M_STORE  = 7'h23;
    localparam logic [6:0] M_OPIMM  = 7'h13;
    localparam logic [6:0] M_OP     = 7'h33;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_i = 1'b1;
    always #5 clk = ~clk;

    logic        imem_req_o, imem_gnt_i, imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        dmem_req_o, dmem_we_o, dmem_gnt_i, dmem_rvalid_i;
    logic        branch_taken_i;
    logic [3:0]  alu_op_o;
    logic        data_a_mux_o, data_b_mux_o;
    logic [2:0]  imm_sel_o;
    logic [4:0]  reg_raddr_a_o, reg_raddr_b_o, reg_waddr_o;
    logic        reg_we_o;
    logic [1:0]  wb_sel_o, pc_mux_o;
    logic        pc_we_o, illegal_instr_o;
    state_t      dbg_state;

    control_fsm #(.ADDR_WIDTH(5), .ALU_OP_WIDTH(4)) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .imem_req_o      (imem_req_o),
        .imem_gnt_i      (imem_gnt_i),
        .imem_rvalid_i   (imem_rvalid_i),
        .imem_rdata_i    (imem_rdata_i),
        .dmem_req_o      (dmem_req_o),
        .dmem_we_o       (dmem_we_o),
        .dmem_gnt_i      (dmem_gnt_i),
        .dmem_rvalid_i   (dmem_rvalid_i),
        .branch_taken_i  (branch_taken_i),
        .alu_op_o        (alu_op_o),
        .data_a_mux_o    (data_a_mux_o),
        .data_b_mux_o    (data_b_mux_o),
        .imm_sel_o       (imm_sel_o),
        .reg_raddr_a_o   (reg_raddr_a_o),
        .reg_raddr_b_o   (reg_raddr_b_o),
        .reg_waddr_o     (reg_waddr_o),
        .reg_we_o        (reg_we_o),
        .wb_sel_o        (wb_sel_o),
        .pc_mux_o        (pc_mux_o),
        .pc_we_o         (pc_we_o),
        .illegal_instr_o (illegal_instr_o),
        .state_o         (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;
    logic [31:0] cur_ir;
    // Per-cycle inputs {imem_gnt, imem_rvalid, dmem_gnt, dmem_rvalid},
    // expected strobes {imem_req, dmem_req, dmem_we, reg_we, pc_we, pc_mux[1:0], illegal},
    // and whether decode outputs must match the current instruction that cycle.
    logic [3:0] in_q[$];
    logic [7:0] exp_q[$];
    bit         chk_q[$];

    wire [7:0]  strobes_obs = {imem_req_o, dmem_req_o, dmem_we_o, reg_we_o, pc_we_o, pc_mux_o, illegal_instr_o};
    wire [25:0] dec_obs = {alu_op_o, data_a_mux_o, data_b_mux_o, imm_sel_o, wb_sel_o,
                           reg_raddr_a_o, reg_raddr_b_o, reg_waddr_o};
    wire [33:0] all_obs = {imem_req_o, dmem_req_o, dmem_we_o, alu_op_o, data_a_mux_o, data_b_mux_o,
                           imm_sel_o, reg_raddr_a_o, reg_raddr_b_o, reg_waddr_o, reg_we_o,
                           wb_sel_o, pc_mux_o, pc_we_o, illegal_instr_o};

    task automatic check(input string tag, input logic [33:0] obs, input logic [33:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit m_legal(input logic [31:0] ir);
        return ir[6:0] inside {M_LUI, M_AUIPC, M_JAL, M_JALR, M_BRANCH, M_LOAD, M_STORE, M_OPIMM, M_OP};
    endfunction

    function automatic logic [25:0] m_decode(input logic [31:0] ir);
        logic [6:0] op;
        logic [2:0] f3;
        logic [3:0] alu;
        logic       a, b;
        logic [2:0] imm;
        logic [1:0] wb;
        op  = ir[6:0];
        f3  = ir[14:12];
        alu = 4'd0;
        if (op == M_OP) alu = {ir[30], f3};
        else if (op == M_OPIMM) alu = {(f3 == 3'b101) ? ir[30] : 1'b0, f3};
        a = (op == M_AUIPC) || (op == M_JAL) || (op == M_BRANCH);
        b = m_legal(ir) && (op != M_OP) && (op != M_BRANCH);
        case (op)
            M_STORE:        imm = 3'd1;
            M_BRANCH:       imm = 3'd2;
            M_LUI, M_AUIPC: imm = 3'd3;
            M_JAL:          imm = 3'd4;
            default:        imm = 3'd0;
        endcase
        wb = (op == M_JAL || op == M_JALR) ? 2'd2 : (op == M_LOAD) ? 2'd1 : 2'd0;
        return {alu, a, b, imm, wb, ir[19:15], ir[24:20], ir[11:7]};
    endfunction

    function automatic logic [7:0] strobe(input bit ireq, input bit dreq, input bit dwe, input bit rwe,
                                          input bit pwe, input logic [1:0] pmux, input bit ill);
        return {ireq, dreq, dwe, rwe, pwe, pmux, ill};
    endfunction

    task automatic push(input logic [3:0] v, input logic [7:0] e, input bit c);
        in_q.push_back(v);
        exp_q.push_back(e);
        chk_q.push_back(c);
    endtask

    // Expected cycle-by-cycle trace of one instruction, given the wait
    // cycles inserted before each grant / valid.
    task automatic build(input logic [31:0] ir, input int gw, input int rw, input int dgw,
                         input int drw, input bit taken, input int trap_n);
        logic [6:0] op;
        bit st, ld, jmp, rd_nz;
        op = ir[6:0];
        st = (op == M_STORE);
        ld = (op == M_LOAD);
        jmp = (op == M_JAL) || (op == M_JALR);
        rd_nz = (ir[11:7] != 5'd0);
        cur_ir = ir;
        imem_rdata_i = ir;
        branch_taken_i = taken;
        for (int i = 0; i < gw; i++) push(4'b0000, strobe(1, 0, 0, 0, 0, 2'd0, 0), 0);
        push(4'b1000, strobe(1, 0, 0, 0, 0, 2'd0, 0), 0);
        for (int i = 0; i < rw; i++) push(4'b0000, 8'h00, 0);
        push(4'b0100, 8'h00, 0);
        push(4'b0000, 8'h00, 0);                       // decode
        if (!m_legal(ir)) begin
            for (int i = 0; i < trap_n; i++) push(4'b1111, strobe(0, 0, 0, 0, 0, 2'd0, 1), 0);
            return;
        end
        if (op == M_BRANCH) begin
            push(4'b0000, strobe(0, 0, 0, 0, 1, taken ? 2'd2 : 2'd0, 0), 1);
            return;
        end
        push(4'b0000, 8'h00, 1);                       // exec
        if (ld || st) begin
            for (int i = 0; i < dgw; i++) push(4'b0000, strobe(0, 1, st, 0, 0, 2'd0, 0), 1);
            push(4'b0010, strobe(0, 1, st, 0, st, 2'd0, 0), 1);
            if (st) return;
            for (int i = 0; i < drw; i++) push(4'b0000, 8'h00, 1);
            push(4'b0001, 8'h00, 1);
        end
        push(4'b0000, strobe(0, 0, 0, rd_nz, 1, jmp ? 2'd1 : 2'd0, 0), 1);
    endtask

    // ---------------- driver ----------------
    // Entered at posedge+1; drives one queue entry per cycle, checks at negedge.
    task automatic play(input int n, input string tag);
        int k;
        k = 0;
        while (in_q.size() > 0 && k < n) begin
            logic [3:0] v;
            logic [7:0] e;
            bit c;
            v = in_q.pop_front();
            e = exp_q.pop_front();
            c = chk_q.pop_front();
            {imem_gnt_i, imem_rvalid_i, dmem_gnt_i, dmem_rvalid_i} = v;
            @(negedge clk);
            check($sformatf("%s strobes c%0d", tag, k), 34'(strobes_obs), 34'(e));
            if (c) check($sformatf("%s decode c%0d", tag, k), 34'(dec_obs), 34'(m_decode(cur_ir)));
            @(posedge clk);
            #1;
            k++;
        end
        {imem_gnt_i, imem_rvalid_i, dmem_gnt_i, dmem_rvalid_i} = 4'b0000;
    endtask

    task automatic run(input logic [31:0] ir, input int gw, input int rw, input int dgw,
                       input int drw, input bit taken, input string tag);
        build(ir, gw, rw, dgw, drw, taken, 0);
        play(1000, tag);
    endtask

    // Reset pulse over one edge, then verify the fetch request on release.
    task automatic reset_seq(input string tag);
        rst_i = 1'b1;
        #1;
        check({tag, " during reset"}, all_obs, 34'd0);
        @(posedge clk);
        #1;
        in_q.delete();
        exp_q.delete();
        chk_q.delete();
        rst_i = 1'b0;
        @(negedge clk);
        check({tag, " after release"}, 34'(strobes_obs), 34'(strobe(1, 0, 0, 0, 0, 2'd0, 0)));
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_legal();
        logic [31:0] r;
        logic [6:0]  op;
        r = $urandom();
        case ($urandom_range(0, 8))
            0: op = M_LUI;
            1: op = M_AUIPC;
            2: op = M_JAL;
            3: op = M_JALR;
            4: op = M_BRANCH;
            5: op = M_LOAD;
            6: op = M_STORE;
            7: op = M_OPIMM;
            default: op = M_OP;
        endcase
        return {r[31:7], op};
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] ir;
        logic [6:0]  bad;
        imem_gnt_i = 0; imem_rvalid_i = 0; imem_rdata_i = 0;
        dmem_gnt_i = 0; dmem_rvalid_i = 0; branch_taken_i = 0;
        cur_ir = 0;

        @(negedge clk);
        check("reset outputs", all_obs, 34'd0);
        @(posedge clk);
        #1;
        rst_i = 1'b0;

        run(32'h00500093, 0, 0, 0, 0, 0, "addi");           // ADDI x1,x0,5
        run(32'h0000A103, 0, 0, 3, 1, 0, "lw");             // LW x2,0(x1)
        run(32'h00208463, 0, 0, 0, 0, 1, "beq_taken");      // BEQ x1,x2,+8
        run(32'h00208463, 0, 0, 0, 0, 0, "beq_not");
        run(32'h00208033, 0, 0, 0, 0, 0, "add_x0");         // ADD x0,x1,x2
        run(32'h008000EF, 1, 2, 0, 0, 0, "jal");            // JAL x1,+8
        run(32'h0020A223, 2, 0, 2, 0, 0, "sw");             // SW x2,4(x1)
        run(32'h4050D093, 0, 1, 0, 0, 0, "srai");           // SRAI x1,x1,5

        for (int i = 0; i < 50; i++) begin
            run(rand_legal(), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                $sformatf("rand%0d", i));
        end

        // Reset while waiting for load data.
        build(32'h0000A103, 0, 0, 0, 3, 0, 0);
        play(6, "lw_pre_rst");
        #2;
        reset_seq("rst_wait_d");

        // Illegal opcode: flag rises after DECODE and holds for 20 cycles.
        build(32'h0000007F, 0, 0, 0, 0, 0, 20);
        play(1000, "illegal");
        reset_seq("rst_trap");

        for (int i = 0; i < 3; i++) begin
            do begin
                bad = 7'($urandom_range(0, 127));
                ir = {$urandom(), bad};
            end while (m_legal(ir));
            build(ir, $urandom_range(0, 2), $urandom_range(0, 2), 0, 0, 0, 4);
            play(1000, $sformatf("rand_illegal%0d", i));
            reset_seq($sformatf("rst_illegal%0d", i));
        end

        run(rand_legal(), 0, 0, 0, 0, 1, "post_trap");
        run(32'h00500093, 0, 0, 0, 0, 0, "addi_end");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
